// File: rtl/uart_recv.sv
// UART receiver: 8 data bits LSB first, 1 start, 1 stop, mid-bit sampling with a per-bit baud counter.
// Optional: define UART_RX_PARITY_EN to expect an even parity bit after bit 7 and expose parity_err.
module uart_recv #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int UART_BPS = 115200
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       uart_rxd,
  output logic       uart_done,
  output logic [7:0] uart_data,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       frame_err
);

  localparam int BPS_CNT = CLK_FREQ / UART_BPS;
  localparam int CW = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
  localparam logic [CW-1:0] C_HALF = CW'(BPS_CNT / 2 - 1);
  localparam logic [CW-1:0] C_FULL = CW'(BPS_CNT - 1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [CW-1:0] C_ZERO = CW'(0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3
`ifdef UART_RX_PARITY_EN
    , S_PARITY = 3'd4
`endif
  } state_t;

`ifdef UART_RX_PARITY_EN
  function automatic logic f_parity_bad(input logic [7:0] data, input logic par);
    return (^data) ^ par;
  endfunction
`endif

  state_t          r_state;
  logic            r_rxd_s1;
  logic            r_rxd_s2;
  logic            r_rxd_d;
  logic [CW-1:0]   r_clk_cnt;
  logic [2:0]      r_bit_cnt;
  logic [7:0]      r_shift;
  logic [7:0]      r_data;
  logic            r_done;
  logic            r_ferr;
`ifdef UART_RX_PARITY_EN
  logic            r_par;
  logic            r_perr;
`endif
  logic            w_start_edge;

  // Falling edge of the synchronised line starts a frame; a line held low never retriggers.
  assign w_start_edge = r_rxd_d & ~r_rxd_s2;

  assign uart_done = r_done;
  assign uart_data = r_data;
  assign frame_err = r_ferr;
`ifdef UART_RX_PARITY_EN
  assign parity_err = r_perr;
`endif

  // Synchroniser, receive FSM and registered strobes.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_rxd_s1  <= 1'b1;
      r_rxd_s2  <= 1'b1;
      r_rxd_d   <= 1'b1;
      r_state   <= S_IDLE;
      r_clk_cnt <= C_ZERO;
      r_bit_cnt <= 3'd0;
      r_shift   <= 8'h00;
      r_data    <= 8'h00;
      r_done    <= 1'b0;
      r_ferr    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par     <= 1'b0;
      r_perr    <= 1'b0;
`endif
    end else begin
      r_rxd_s1 <= uart_rxd;
      r_rxd_s2 <= r_rxd_s1;
      r_rxd_d  <= r_rxd_s2;
      r_done   <= 1'b0;
      r_ferr   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr   <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          r_clk_cnt <= C_ZERO;
          if (w_start_edge) r_state <= S_START;
          else              r_state <= S_IDLE;
        end
        S_START: begin
          // Start bit re-checked at its middle so short low glitches are rejected.
          if (r_clk_cnt == C_HALF) begin
            r_clk_cnt <= C_ZERO;
            r_bit_cnt <= 3'd0;
            if (r_rxd_s2) r_state <= S_IDLE;
            else          r_state <= S_DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + C_ONE;
          end
        end
        S_DATA: begin
          if (r_clk_cnt == C_FULL) begin
            r_clk_cnt          <= C_ZERO;
            r_shift[r_bit_cnt] <= r_rxd_s2;
            if (r_bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + C_ONE;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (r_clk_cnt == C_FULL) begin
            r_clk_cnt <= C_ZERO;
            r_par     <= r_rxd_s2;
            r_state   <= S_STOP;
          end else begin
            r_clk_cnt <= r_clk_cnt + C_ONE;
          end
        end
`endif
        S_STOP: begin
          // Leaving at stop mid-bit leaves half a bit to catch a back-to-back start edge.
          if (r_clk_cnt == C_FULL) begin
            r_clk_cnt <= C_ZERO;
            r_state   <= S_IDLE;
            if (!r_rxd_s2) begin
              r_ferr <= 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            else if (f_parity_bad(r_shift, r_par)) begin
              r_perr <= 1'b1;
            end
`endif
            else begin
              r_done <= 1'b1;
              r_data <= r_shift;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + C_ONE;
          end
        end
        default: begin
          r_clk_cnt <= C_ZERO;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_recv.sv
// Self-checking bench for uart_recv at 10 clocks per bit; strobes are logged by a monitor
// and compared against outcomes predicted from the frames the bench itself transmits.
`timescale 1ns/1ps
module tb_uart_recv;
  localparam int BPS = 10;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * BPS;
  localparam int LAT   = 3 + BPS / 2 + (NBITS - 1) * BPS;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       uart_rxd;
  logic       uart_done;
  logic [7:0] uart_data;
  logic       frame_err;
  logic       perr_s;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int multi_cnt = 0;
  int       ob_k[$];
  int       ob_t[$];
  logic [7:0] ob_d[$];

  uart_recv #(.CLK_FREQ(1_000_000), .UART_BPS(100_000)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .uart_rxd  (uart_rxd),
    .uart_done (uart_done),
    .uart_data (uart_data),
`ifdef UART_RX_PARITY_EN
    .parity_err(perr_s),
`endif
    .frame_err (frame_err)
  );
`ifndef UART_RX_PARITY_EN
  assign perr_s = 1'b0;
`endif

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Event log: kind 0 = good byte, 1 = framing error, 2 = parity error.
  always @(negedge sys_clk) begin
    if (uart_done) begin ob_k.push_back(0); ob_t.push_back(cyc); ob_d.push_back(uart_data); end
    if (frame_err) begin ob_k.push_back(1); ob_t.push_back(cyc); ob_d.push_back(uart_data); end
    if (perr_s)    begin ob_k.push_back(2); ob_t.push_back(cyc); ob_d.push_back(uart_data); end
    if (int'(uart_done) + int'(frame_err) + int'(perr_s) > 1) multi_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge sys_clk); #1; end
  endtask

  task automatic clear_log();
    ob_k.delete(); ob_t.delete(); ob_d.delete();
  endtask

  function automatic logic even_par(input logic [7:0] d);
    return ^d;
  endfunction

  // Reference outcome of one frame from the line-level rules.
  function automatic int outcome(input logic [7:0] d, input logic stop_b, input logic par_b);
    if (stop_b == 1'b0) return 1;
`ifdef UART_RX_PARITY_EN
    if (par_b != even_par(d)) return 2;
`endif
    return 0;
  endfunction

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b, output int t0);
    logic [NBITS-1:0] bits;
`ifdef UART_RX_PARITY_EN
    bits = {stop_b, par_b, d, 1'b0};
`else
    bits = {stop_b, d, 1'b0};
`endif
    t0 = cyc;
    for (int i = 0; i < NBITS; i++) begin
      uart_rxd = bits[i];
      tick(BPS);
    end
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    uart_rxd  = 1'b1;
    tick(3);
    n_cmp++; if (uart_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", uart_done); end
    n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
    n_cmp++; if (uart_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", uart_data); end
    sys_rst_n = 1'b1;
    tick(5);
  endtask

  task automatic test_single();
    int t0;
    clear_log();
    send_frame(8'hAA, 1'b1, even_par(8'hAA), t0);
    uart_rxd = 1'b1;
    tick(30);
    n_cmp++; if (ob_k.size() !== 1) begin n_err++; $display("FAIL single_count: got %0d events want 1", ob_k.size()); end
    if (ob_k.size() > 0) begin
      n_cmp++; if (ob_k[0] !== 0) begin n_err++; $display("FAIL single_kind: got %0d want 0", ob_k[0]); end
      n_cmp++; if (ob_d[0] !== 8'hAA) begin n_err++; $display("FAIL single_data: got %h want aa", ob_d[0]); end
      n_cmp++; if (ob_t[0] - t0 < LAT - 1 || ob_t[0] - t0 > LAT + 1) begin
        n_err++; $display("FAIL single_latency: got %0d want %0d+-1", ob_t[0] - t0, LAT); end
    end
  endtask

  task automatic test_back_to_back();
    int t0, t1;
    clear_log();
    send_frame(8'h55, 1'b1, even_par(8'h55), t0);
    send_frame(8'h00, 1'b1, even_par(8'h00), t1);
    uart_rxd = 1'b1;
    tick(30);
    n_cmp++; if (ob_k.size() !== 2) begin n_err++; $display("FAIL b2b_count: got %0d events want 2", ob_k.size()); end
    if (ob_k.size() == 2) begin
      n_cmp++; if (ob_d[0] !== 8'h55 || ob_k[0] !== 0) begin n_err++; $display("FAIL b2b_first: got %h kind %0d want 55 kind 0", ob_d[0], ob_k[0]); end
      n_cmp++; if (ob_d[1] !== 8'h00 || ob_k[1] !== 0) begin n_err++; $display("FAIL b2b_second: got %h kind %0d want 00 kind 0", ob_d[1], ob_k[1]); end
      n_cmp++; if (ob_t[1] - ob_t[0] !== t1 - t0) begin n_err++; $display("FAIL b2b_spacing: got %0d want %0d", ob_t[1] - ob_t[0], t1 - t0); end
    end
  endtask

  task automatic test_glitch();
    int t0;
    clear_log();
    uart_rxd = 1'b0;
    tick(3);
    uart_rxd = 1'b1;
    tick(30);
    n_cmp++; if (ob_k.size() !== 0) begin n_err++; $display("FAIL glitch_strobe: got %0d events want 0", ob_k.size()); end
    send_frame(8'h3C, 1'b1, even_par(8'h3C), t0);
    uart_rxd = 1'b1;
    tick(30);
    n_cmp++; if (ob_k.size() !== 1) begin n_err++; $display("FAIL glitch_next_count: got %0d want 1", ob_k.size()); end
    n_cmp++; if (uart_data !== 8'h3C) begin n_err++; $display("FAIL glitch_next_data: got %h want 3c", uart_data); end
  endtask

  task automatic test_frame_err();
    int t0;
    clear_log();
    send_frame(8'hF0, 1'b0, even_par(8'hF0), t0);
    uart_rxd = 1'b1;
    tick(30);
    n_cmp++; if (ob_k.size() !== 1) begin n_err++; $display("FAIL ferr_count: got %0d want 1", ob_k.size()); end
    if (ob_k.size() > 0) begin
      n_cmp++; if (ob_k[0] !== 1) begin n_err++; $display("FAIL ferr_kind: got %0d want 1", ob_k[0]); end
      n_cmp++; if (ob_t[0] - t0 < LAT - 1 || ob_t[0] - t0 > LAT + 1) begin
        n_err++; $display("FAIL ferr_latency: got %0d want %0d+-1", ob_t[0] - t0, LAT); end
    end
    n_cmp++; if (uart_data !== 8'h3C) begin n_err++; $display("FAIL ferr_data_hold: got %h want 3c", uart_data); end
  endtask

  task automatic test_reset_mid_frame();
    int t0;
    clear_log();
    fork
      send_frame(8'hF1, 1'b1, even_par(8'hF1), t0);
      begin
        tick(5 * BPS + 5);
        sys_rst_n = 1'b0;
        tick(2);
        sys_rst_n = 1'b1;
      end
    join
    uart_rxd = 1'b1;
    tick(30);
    n_cmp++; if (ob_k.size() !== 0) begin n_err++; $display("FAIL rstmid_strobe: got %0d events want 0", ob_k.size()); end
    n_cmp++; if (uart_data !== 8'h00) begin n_err++; $display("FAIL rstmid_data: got %h want 00", uart_data); end
    send_frame(8'h81, 1'b1, even_par(8'h81), t0);
    uart_rxd = 1'b1;
    tick(30);
    n_cmp++; if (ob_k.size() !== 1 || uart_data !== 8'h81) begin
      n_err++; $display("FAIL rstmid_next: got %0d events data %h want 1 event data 81", ob_k.size(), uart_data); end
  endtask

  task automatic test_loopback();
    int t0;
    clear_log();
    send_frame(8'b1010_1010, 1'b1, even_par(8'b1010_1010), t0);
    uart_rxd = 1'b1;
    tick(30);
    n_cmp++; if (ob_k.size() !== 1 || uart_data !== 8'b1010_1010) begin
      n_err++; $display("FAIL loop_data: got %0d events data %h want 1 event data aa", ob_k.size(), uart_data); end
`ifdef UART_RX_PARITY_EN
    clear_log();
    send_frame(8'h07, 1'b1, 1'b0, t0);
    uart_rxd = 1'b1;
    tick(30);
    n_cmp++; if (ob_k.size() !== 1) begin n_err++; $display("FAIL perr_count: got %0d want 1", ob_k.size()); end
    if (ob_k.size() > 0) begin
      n_cmp++; if (ob_k[0] !== 2) begin n_err++; $display("FAIL perr_kind: got %0d want 2", ob_k[0]); end
    end
    n_cmp++; if (uart_data !== 8'hAA) begin n_err++; $display("FAIL perr_data_hold: got %h want aa", uart_data); end
`endif
  endtask

  task automatic test_random();
    int ex_k[$];
    int ex_t[$];
    logic [7:0] ex_d[$];
    logic [7:0] last_good, d;
    logic stop_b, par_b, prev_stop;
    int t0, gap, k;
    clear_log();
    last_good = uart_data;
    prev_stop = 1'b1;
    for (int f = 0; f < 16; f++) begin
      d      = 8'($urandom);
      stop_b = ($urandom_range(0, 4) != 0);
      par_b  = ($urandom_range(0, 3) != 0) ? even_par(d) : ~even_par(d);
      gap    = prev_stop ? $urandom_range(0, 12) : $urandom_range(4, 12);
      uart_rxd = 1'b1;
      tick(gap);
      send_frame(d, stop_b, par_b, t0);
      k = outcome(d, stop_b, par_b);
      if (k == 0) last_good = d;
      ex_k.push_back(k); ex_t.push_back(t0 + LAT); ex_d.push_back(last_good);
      prev_stop = stop_b;
    end
    uart_rxd = 1'b1;
    tick(30);
    n_cmp++; if (ob_k.size() !== ex_k.size()) begin
      n_err++; $display("FAIL rand_count: got %0d events want %0d", ob_k.size(), ex_k.size()); end
    for (int i = 0; i < ex_k.size() && i < ob_k.size(); i++) begin
      n_cmp++;
      if (ob_k[i] !== ex_k[i] || ob_d[i] !== ex_d[i] || ob_t[i] < ex_t[i] - 1 || ob_t[i] > ex_t[i] + 1) begin
        n_err++;
        $display("FAIL rand_frame%0d: got kind %0d data %h t %0d want kind %0d data %h t %0d+-1",
                 i, ob_k[i], ob_d[i], ob_t[i], ex_k[i], ex_d[i], ex_t[i]);
      end
    end
    n_cmp++; if (uart_data !== last_good) begin n_err++; $display("FAIL rand_final_data: got %h want %h", uart_data, last_good); end
    n_cmp++; if (multi_cnt !== 0) begin n_err++; $display("FAIL strobe_exclusive: got %0d overlaps want 0", multi_cnt); end
  endtask

  initial begin
    sys_rst_n = 1'b0;
    uart_rxd  = 1'b1;
    tick(1);
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid_frame();
    test_loopback();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_recv.md
Name: uart_recv

Overview:
Asynchronous UART receiver for the Bluetooth link: 8 data bits, LSB first, 1 start bit, 1 stop bit, no parity by default.
Samples uart_rxd at mid-bit using a per-bit baud counter and presents each received byte with a one-cycle done strobe.
Sits directly downstream of uart_send on the serial line; used for loopback checking and for receiving from the BT module.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
UART_BPS, 115200, baud rate; derived localparam BPS_CNT = CLK_FREQ/UART_BPS (integer division), must be >= 4

Ports:
sys_clk  input  1  system clock, all logic on rising edge
sys_rst_n  input  1  synchronous active-low reset
uart_rxd  input  1  serial line, idle high, asynchronous to sys_clk
uart_done  output  1  one-cycle strobe, uart_data valid and updated this cycle
uart_data  output  8  last correctly framed byte, held until next good frame
frame_err  output  1  one-cycle strobe, stop bit sampled low

Behaviour:
- Reset (sys_rst_n low at a sys_clk edge): state=IDLE, counters=0, synchronizer flops=1, uart_done=0, uart_data=8'h00, frame_err=0. Reset mid-frame abandons the frame; no strobe.
- Input path: 2-flop synchronizer on uart_rxd (rxd_s1, rxd_s2), plus 1 delay flop rxd_d for edge detection; start_edge = rxd_d & ~rxd_s2.
- clk_cnt: width ceil(log2(BPS_CNT)); cleared on every state entry and on every bit sample.
- bit_cnt: 0..7, data bit index.
- FSM states:
  - IDLE: on start_edge -> START (clk_cnt=0). Otherwise hold.
  - START: count to BPS_CNT/2-1, then sample rxd_s2. If 1 (glitch) -> IDLE with no strobe. If 0 -> DATA, bit_cnt=0.
  - DATA: count to BPS_CNT-1, then sample rxd_s2 into shift[bit_cnt] (LSB first). After bit 7 -> STOP.
  - STOP: count to BPS_CNT-1, then sample rxd_s2.
    - If 1: uart_data<=shift and uart_done=1 for exactly one cycle.
    - If 0: frame_err=1 for one cycle; uart_data unchanged.
    - Either way -> IDLE in the same cycle.
- Latency: uart_done/frame_err asserts 3 + BPS_CNT/2 + 9*BPS_CNT cycles (±1) after the first edge at which uart_rxd is sampled low.
- Back-to-back frames: return to IDLE at stop mid-bit allows a new start edge half a bit later; no frames lost at full line rate.
- Break/line held low after a frame error: no new frame until the line returns high and falls again (edge-triggered start).
- uart_done and frame_err are never asserted together. Both are registered outputs.

Optional Feature:
Macro UART_RX_PARITY_EN.
- Defined: an EVEN parity bit follows data bit 7. A PARITY state samples it at mid-bit after BPS_CNT cycles. Adds output port parity_err (1 bit, reset 0), a one-cycle strobe raised at the stop sample when the XOR of the 8 data bits and the parity bit is 1. On parity error uart_done stays 0 and uart_data is unchanged. Latency grows by BPS_CNT.
- Undefined: no PARITY state, no parity_err port; behaviour as above.

Test Plan:
All scenarios use CLK_FREQ=1_000_000, UART_BPS=100_000 (BPS_CNT=10); a bench task drives frames at 10 cycles/bit.
1. Single frame 8'hAA -> exactly one uart_done pulse 98±1 cycles after the start edge; uart_data=8'hAA; frame_err stays 0.
2. Back-to-back 8'h55 then 8'h00, no idle between frames -> two uart_done pulses 100 cycles apart; uart_data=8'h55 then 8'h00.
3. Low glitch of 3 cycles on an idle line -> no uart_done, no frame_err; FSM back in IDLE; a following 8'h3C is received correctly.
4. Frame 8'hF0 with stop bit driven 0 -> frame_err pulse, no uart_done; uart_data keeps its previous value.
5. sys_rst_n low for 2 cycles during data bit 4 -> no strobes; uart_data=8'h00; the next frame 8'h81 is received correctly.
6. Loopback: uart_send uart_txd to uart_rxd with matching parameters, send 8'b1010_1010 -> uart_done with uart_data=8'b1010_1010. With UART_RX_PARITY_EN: 8'h07 sent with parity 0 -> parity_err pulse, no uart_done.
